// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: carries the decoded control word, destination register and
// valid bit from ID through DEPTH datapath stages (0 = EX ... DEPTH-1 = WB).
// Provides global hold, bubble injection at entry, per-stage flush, plus the
// load-use hazard and forwarding-select outputs used next to the register file.
module ctrl_pipe_chain #(
    parameter int CW       = 22,
    parameter int DEPTH    = 3,
    parameter int LOAD_BIT = 10,
    parameter int RFEN_BIT = 9,
    parameter int SW       = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CW-1:0]         id_ctrl,
    input  logic                  id_valid,
    input  logic [4:0]            id_dest,
    input  logic [4:0]            id_rs,
    input  logic [4:0]            id_rt,
    input  logic                  nop_sel,
    input  logic                  hold,
    input  logic [DEPTH-1:0]      flush,
    output logic [DEPTH*CW-1:0]   stage_ctrl,
    output logic [DEPTH-1:0]      stage_valid,
    output logic [DEPTH*5-1:0]    stage_dest,
    output logic                  load_use_hazard,
    output logic [SW-1:0]         fwd_rs_sel,
    output logic [SW-1:0]         fwd_rt_sel,
    output logic [SW-1:0]         occupancy,
    output logic                  retire
);

    logic [CW-1:0]    ctrl_q [DEPTH];
    logic [CW-1:0]    ctrl_d [DEPTH];
    logic [4:0]       dest_q [DEPTH];
    logic [4:0]       dest_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [SW-1:0]    occ_q;
    logic [SW-1:0]    occ_d;

    // A stage can supply a forwarded operand only if it holds a live writer of
    // a non-zero register equal to the requested source.
    function automatic logic stage_hits(input logic vld, input logic rfen,
                                        input logic [4:0] dst, input logic [4:0] src);
        return vld && rfen && (dst != 5'd0) && (dst == src);
    endfunction

    // Next-state of every stage: flush beats hold, hold beats advance; stage 0
    // takes the ID word only when it is a real instruction and no bubble is forced.
    always_comb begin
        if (flush[0]) begin
            ctrl_d[0]  = '0;
            valid_d[0] = 1'b0;
            dest_d[0]  = '0;
        end else if (hold) begin
            ctrl_d[0]  = ctrl_q[0];
            valid_d[0] = valid_q[0];
            dest_d[0]  = dest_q[0];
        end else if (nop_sel || !id_valid) begin
            ctrl_d[0]  = '0;
            valid_d[0] = 1'b0;
            dest_d[0]  = '0;
        end else begin
            ctrl_d[0]  = id_ctrl;
            valid_d[0] = 1'b1;
            dest_d[0]  = id_dest;
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (flush[k]) begin
                ctrl_d[k]  = '0;
                valid_d[k] = 1'b0;
                dest_d[k]  = '0;
            end else if (hold) begin
                ctrl_d[k]  = ctrl_q[k];
                valid_d[k] = valid_q[k];
                dest_d[k]  = dest_q[k];
            end else begin
                ctrl_d[k]  = ctrl_q[k-1];
                valid_d[k] = valid_q[k-1];
                dest_d[k]  = dest_q[k-1];
            end
        end
    end

    // Occupancy is registered from the next valid vector so it tracks stage_valid exactly.
    always_comb begin
        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + SW'(valid_d[k]);
        end
    end

    // Stage registers; reset empties the whole chain asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                ctrl_q[k] <= '0;
                dest_q[k] <= '0;
            end
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                ctrl_q[k] <= ctrl_d[k];
                dest_q[k] <= dest_d[k];
            end
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    // Pack per-stage state onto the flat output buses.
    always_comb begin
        stage_ctrl = '0;
        stage_dest = '0;
        for (int k = 0; k < DEPTH; k++) begin
            stage_ctrl[k*CW +: CW] = ctrl_q[k];
            stage_dest[k*5 +: 5]   = dest_q[k];
        end
    end

    // Forward selects: scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_rs_sel = SW'(DEPTH);
        fwd_rt_sel = SW'(DEPTH);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (stage_hits(valid_q[k], ctrl_q[k][RFEN_BIT], dest_q[k], id_rs)) begin
                fwd_rs_sel = SW'(k);
            end
            if (stage_hits(valid_q[k], ctrl_q[k][RFEN_BIT], dest_q[k], id_rt)) begin
                fwd_rt_sel = SW'(k);
            end
        end
    end

    assign stage_valid = valid_q;
    assign occupancy   = occ_q;
    assign retire      = valid_q[DEPTH-1] & ~hold & ~flush[DEPTH-1];

    // A load in EX cannot forward in time to a dependent instruction in ID.
    assign load_use_hazard = id_valid & valid_q[0] & ctrl_q[0][LOAD_BIT] &
                             (dest_q[0] != 5'd0) &
                             ((dest_q[0] == id_rs) | (dest_q[0] == id_rt));

endmodule

// File: doc/ctrl_pipe_chain.md
Name: ctrl_pipe_chain

Overview:
Parametrised successor to the fixed ID/EX, EX/MEM and MEM/WB control-word registers. It carries the decoded control word, a destination register number and a valid bit through DEPTH pipeline stages. Supports a global hold, bubble (NOP) injection at entry, and per-stage flush. It also produces load-use hazard and forwarding-select outputs for the hazard/forwarding logic next to the register file. It sits between the control unit / NOP mux in ID and the datapath stages EX..WB.

Parameters:
CW, 22, control-word width (bit layout as the control unit's output)
DEPTH, 3, number of stages after ID (index 0 = EX, DEPTH-1 = WB); legal range 2..8
LOAD_BIT, 10, index of the Load_Instr bit in the control word
RFEN_BIT, 9, index of the RF_Enable bit in the control word
SW, $clog2(DEPTH+1), width of the forwarding-select and count outputs (derived)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
id_ctrl  in  CW  control word from the control unit (ID stage)
id_valid  in  1  ID holds a real instruction
id_dest  in  5  destination register of the ID instruction (rd/rt/r31, already muxed)
id_rs  in  5  rs field of the ID instruction
id_rt  in  5  rt field of the ID instruction
nop_sel  in  1  force a bubble into stage 0 (NOP mux select)
hold  in  1  freeze all stages this cycle
flush  in  DEPTH  per-stage clear, bit k clears stage k
stage_ctrl  out  DEPTH*CW  packed control words; stage k occupies bits [k*CW +: CW]
stage_valid  out  DEPTH  valid bit per stage
stage_dest  out  DEPTH*5  packed destination register per stage
load_use_hazard  out  1  stall request to PC, nPC and IF/ID
fwd_rs_sel  out  SW  youngest stage whose result matches id_rs; DEPTH = no match
fwd_rt_sel  out  SW  youngest stage whose result matches id_rt; DEPTH = no match
occupancy  out  SW  registered count of valid stages
retire  out  1  the instruction in the last stage commits this cycle

Behaviour:
- Reset (async, any time, including mid-stream): all stage_ctrl = 0, stage_valid = 0, stage_dest = 0, occupancy = 0. Combinational outputs follow: load_use_hazard = 0, fwd_*_sel = DEPTH, retire = 0.
- Bubble definition: ctrl = 0, valid = 0, dest = 0.
- Rising edge with hold = 0:
  - Stage 0 loads a bubble if nop_sel, !id_valid or flush[0]; otherwise it loads {id_ctrl, 1, id_dest}.
  - Stage k>0 loads a bubble if flush[k]; otherwise it loads stage k-1.
  - The last stage's content is discarded after this edge.
- Rising edge with hold = 1: each stage keeps its content, except a stage with flush[k] = 1, which becomes a bubble. Flush has priority over hold.
- Priority at stage 0: flush[0] > nop_sel > id_valid.
- occupancy: registered popcount of the next stage_valid value, so it always equals the number of set bits in stage_valid.
- retire = stage_valid[DEPTH-1] & !hold & !flush[DEPTH-1] (combinational).
- Stage k matches rs when: stage_valid[k] & ctrl_k[RFEN_BIT] & dest_k != 0 & dest_k == id_rs. The rt match is the same with id_rt.
- fwd_rs_sel = lowest k with an rs match, else DEPTH; fwd_rt_sel likewise for rt. Register $0 never forwards.
- load_use_hazard = id_valid & stage_valid[0] & ctrl_0[LOAD_BIT] & dest_0 != 0 & (dest_0 == id_rs | dest_0 == id_rt). It is combinational. The external controller drives nop_sel = 1 the same cycle, so the load advances while a bubble enters.
- Latency: the ID word appears at stage k after k+1 un-held edges.
- No internal reservation: any flush/hold/nop_sel combination is legal every cycle.

Test Plan:
1. Reset mid-stream: load 3 valid words, assert reset between edges → all outputs 0 immediately, occupancy = 0, fwd_*_sel = 3.
2. Streaming: id_ctrl = 0x000201, 0x000202, 0x000203 on 3 edges with id_valid = 1 → after 3rd edge stage_ctrl = {0x000201 (WB), 0x000202, 0x000203 (EX)}, occupancy = 3, retire = 1.
3. Load-use: stage0 ctrl has bit10 = 1, dest = 5, id_rs = 5 → load_use_hazard = 1. With nop_sel = 1 next edge: stage0 becomes a bubble, stage1 dest = 5, hazard = 0, fwd_rs_sel = 1 if the ctrl also has bit9 = 1.
4. Forward priority: stages 0 and 2 both write r7 (bit9 = 1), id_rt = 7 → fwd_rt_sel = 0. With id_rt = 0 and a stage dest = 0 → fwd_rt_sel = 3.
5. Hold with flush: full pipe, hold = 1, flush = 3'b010 → stages 0 and 2 unchanged, stage1 becomes a bubble, occupancy 3 → 2, retire = 0.
6. DEPTH = 5 instance: stream 6 words → word 1 retires on edge 5, occupancy saturates at 5, fwd_*_sel = 5 when no match.
